// File: rtl/dbg_host_seq_if.sv
// Host byte-stream and debug-module command signals of dbg_host_seq.
// master: the sequencer's view; slave: the host link / debug module side.
interface dbg_host_seq_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    logic        busy_o;
    logic        rx_drop_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
        output tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o,
               busy_o, rx_drop_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
        input  tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o,
               busy_o, rx_drop_o
    );
endinterface

// File: rtl/dbg_host_seq.sv
// Host byte-stream to debug-module command sequencer.
// Assembles host frames into debug commands, drives cmd/addr/data with the
// debug module's hold timing, and returns ack/read-data bytes to the host.
// Optional feature: define DBG_SEQ_TIMEOUT_EN to abort memory commands that
// stay in WAIT for TIMEOUT_CYCLES cycles (responds 0xEF).
module dbg_host_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic           clk,
    input  logic           rstn_i,
    dbg_host_seq_if.master bus
);

    localparam logic [7:0] CMD_IDLE    = 8'h00;
    localparam logic [7:0] CMD_READ    = 8'h01;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_LAST    = 8'h07;
    localparam logic [7:0] RSP_ACK     = 8'hA0;
    localparam logic [7:0] RSP_ILLEGAL = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEF;
    localparam logic [2:0] READ_BYTES  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_ADDR,
        S_RX_DATA,
        S_ISSUE,
        S_ARMED,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [2:0]  rleft_q, rleft_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;
    logic [7:0]  cmd_c;
    logic        is_mem;

`ifdef DBG_SEQ_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`endif

    assign is_mem = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);

    assign bus.dbg_cmd_o  = cmd_c;
    assign bus.dbg_addr_o = addr_q;
    assign bus.dbg_data_o = wdata_q;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.busy_o     = busy_q;
    assign bus.rx_drop_o  = drop_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            rleft_q    <= 3'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
`ifdef DBG_SEQ_TIMEOUT_EN
            wcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            rleft_q    <= rleft_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
`ifdef DBG_SEQ_TIMEOUT_EN
            wcnt_q     <= wcnt_d;
`endif
        end
    end

    // Frame decode, command issue/hold and response sequencing
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rleft_d    = rleft_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        drop_d     = 1'b0;
        cmd_c      = CMD_IDLE;
`ifdef DBG_SEQ_TIMEOUT_EN
        wcnt_d     = wcnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid_i && (bus.rx_data_i != CMD_IDLE)) begin
                    cmd_d = bus.rx_data_i;
                    if ((bus.rx_data_i == CMD_READ) || (bus.rx_data_i == CMD_WRITE)) begin
                        cnt_d   = 2'd0;
                        state_d = S_RX_ADDR;
                    end else if (bus.rx_data_i <= CMD_LAST) begin
                        state_d = S_ISSUE;
                    end else begin
                        tx_data_d  = RSP_ILLEGAL;
                        tx_valid_d = 1'b1;
                        rleft_d    = 3'd0;
                        state_d    = S_RESP;
                    end
                end
            end

            S_RX_ADDR: begin
                if (bus.rx_valid_i) begin
                    addr_d = {addr_q[23:0], bus.rx_data_i};
                    cnt_d  = 2'(cnt_q + 2'd1);
                    if (cnt_q == 2'd3) begin
                        if (cmd_q == CMD_WRITE) begin
                            cnt_d   = 2'd0;
                            state_d = S_RX_DATA;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
            end

            S_RX_DATA: begin
                if (bus.rx_valid_i) begin
                    wdata_d = {wdata_q[23:0], bus.rx_data_i};
                    cnt_d   = 2'(cnt_q + 2'd1);
                    if (cnt_q == 2'd3) begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                cmd_c = cmd_q;
                if (is_mem) begin
                    state_d = S_ARMED;
                end else begin
                    tx_data_d  = RSP_ACK | cmd_q;
                    tx_valid_d = 1'b1;
                    rleft_d    = 3'd0;
                    state_d    = S_RESP;
                end
            end

            // Debug module drops ready a cycle late, so ready is not trusted here
            S_ARMED: begin
                cmd_c   = cmd_q;
                state_d = S_WAIT;
`ifdef DBG_SEQ_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end

            // Command withdrawn in the ready cycle so no second access starts
            S_WAIT: begin
                if (bus.dbg_ready_i) begin
                    if (cmd_q == CMD_READ) begin
                        rbuf_d  = bus.dbg_data_i;
                        rleft_d = READ_BYTES;
                    end else begin
                        rleft_d = 3'd0;
                    end
                    tx_data_d  = RSP_ACK | cmd_q;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cmd_c = cmd_q;
`ifdef DBG_SEQ_TIMEOUT_EN
                    if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        tx_data_d  = RSP_TIMEOUT;
                        tx_valid_d = 1'b1;
                        rleft_d    = 3'd0;
                        state_d    = S_RESP;
                    end else begin
                        wcnt_d = WCNT_W'(wcnt_q + 1'b1);
                    end
`endif
                end
            end

            S_RESP: begin
                if (tx_valid_q && bus.tx_ready_i) begin
                    if (rleft_q != 3'd0) begin
                        tx_data_d = rbuf_q[31:24];
                        rbuf_d    = {rbuf_q[23:0], 8'h00};
                        rleft_d   = 3'(rleft_q - 3'd1);
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.rx_valid_i && !(state_q inside {S_IDLE, S_RX_ADDR, S_RX_DATA})) begin
            drop_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule
